// File: rtl/t2mi_pointer_scheduler_if.sv
// Signal bundle between the T2-MI pointer scheduler, the length producer and the packer.
// The master drives the inputs of the scheduler and the slave is the scheduler itself.
interface t2mi_pointer_scheduler_if;
   logic [15:0] LEN_IN;
   logic        LEN_WR;
   logic [11:0] FIFO_USEDW;
   logic        BYTE_TAKEN;
   logic [3:0]  STATE_MON;
   logic        CLR_ERR;
   logic        START;
   logic [7:0]  POINTER;
   logic        RUN;
   logic [3:0]  QUEUE_LEVEL;
   logic [1:0]  ERR;

   modport master (
      output LEN_IN, LEN_WR, FIFO_USEDW, BYTE_TAKEN, STATE_MON, CLR_ERR,
      input  START, POINTER, RUN, QUEUE_LEVEL, ERR
   );

   modport slave (
      input  LEN_IN, LEN_WR, FIFO_USEDW, BYTE_TAKEN, STATE_MON, CLR_ERR,
      output START, POINTER, RUN, QUEUE_LEVEL, ERR
   );
endinterface

// File: rtl/t2mi_pointer_scheduler.sv
// Tracks T2-MI packet boundaries in the payload byte stream and hands the packer
// the pointer / adaptation-field code for each outgoing TS header.
module t2mi_pointer_scheduler #(
   parameter int FILL_THRESHOLD = 184,
   parameter int LEN_DEPTH      = 8
) (
   input logic                      CLK,
   input logic                      RST,
   t2mi_pointer_scheduler_if.slave  bus
);

   localparam int              AW      = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
   localparam logic [3:0]      DEPTH_L = 4'(LEN_DEPTH);
   localparam logic [AW-1:0]   LAST    = AW'(LEN_DEPTH - 1);
   localparam logic [11:0]     THRESH  = 12'(FILL_THRESHOLD);

   typedef enum logic {IDLE, RUNNING} state_t;

   state_t        state, state_nxt;
   logic          start, start_nxt;
   logic [15:0]   len_q [LEN_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [3:0]    level;
   logic [15:0]   rem;
   logic [3:0]    mon_prev;
   logic [7:0]    pointer;
   logic [1:0]    err;

   logic empty, full, pop, push, push_bad, underflow, hdr_entry;

   // Pointer code: unit start if the packet ends within 183 bytes, 1-byte AF at
   // exactly 183, otherwise a full 184-byte payload with no start.
   function automatic logic [7:0] ptr_code(input logic [15:0] r);
      if (r <= 16'd182)      return r[7:0];
      else if (r == 16'd183) return 8'd183;
      else                   return 8'hFF;
   endfunction

   assign empty     = (level == 4'd0);
   assign full      = (level == DEPTH_L);
   assign pop       = bus.BYTE_TAKEN && (rem == 16'd0) && !empty;
   assign push      = bus.LEN_WR && (bus.LEN_IN != 16'd0) && (!full || pop);
   assign push_bad  = bus.LEN_WR && ((bus.LEN_IN == 16'd0) || (full && !pop));
   assign underflow = bus.BYTE_TAKEN && (rem == 16'd0) && empty;
   assign hdr_entry = (bus.STATE_MON == 4'h1) && (mon_prev != 4'h1);

   always_comb begin
      state_nxt = state;
      start_nxt = 1'b0;
      if (state == IDLE && !empty && bus.FIFO_USEDW >= THRESH) begin
         state_nxt = RUNNING;
         start_nxt = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         start <= 1'b0;
      end else begin
         state <= state_nxt;
         start <= start_nxt;
      end
   end

   // Length storage carries no reset; validity is tracked by level and pointers.
   always_ff @(posedge CLK) begin
      if (push) len_q[wr_ptr] <= bus.LEN_IN;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= 4'd0;
         rem      <= 16'd0;
         mon_prev <= 4'd0;
         pointer  <= 8'd0;
         err      <= 2'b00;
      end else begin
         if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 4'd1;
            2'b01:   level <= level - 4'd1;
            default: level <= level;
         endcase
         // The byte that pops a new length is that packet's first byte.
         if (bus.BYTE_TAKEN) begin
            if (rem != 16'd0) rem <= rem - 16'd1;
            else if (!empty)  rem <= len_q[rd_ptr] - 16'd1;
         end
         mon_prev <= bus.STATE_MON;
         if (hdr_entry) pointer <= ptr_code(rem);
         if (bus.CLR_ERR) err <= 2'b00;
         else begin
            if (push_bad)  err[0] <= 1'b1;
            if (underflow) err[1] <= 1'b1;
         end
      end
   end

   assign bus.START       = start;
   assign bus.POINTER     = pointer;
   assign bus.RUN         = (state == RUNNING);
   assign bus.QUEUE_LEVEL = level;
   assign bus.ERR         = err;

endmodule

// File: tb/tb_t2mi_pointer_scheduler.sv
// Directed bench for t2mi_pointer_scheduler: start gating, pointer codes, queue errors, reset.
module tb_t2mi_pointer_scheduler;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   t2mi_pointer_scheduler_if bus ();

   t2mi_pointer_scheduler #(.FILL_THRESHOLD(184), .LEN_DEPTH(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [15:0] len);
      bus.LEN_IN = len;
      bus.LEN_WR = 1'b1;
      tick();
      bus.LEN_WR = 1'b0;
   endtask

   task automatic take(input int n);
      bus.BYTE_TAKEN = 1'b1;
      repeat (n) tick();
      bus.BYTE_TAKEN = 1'b0;
   endtask

   task automatic header();
      bus.STATE_MON = 4'h1;
      tick();
      bus.STATE_MON = 4'h3;
      tick();
      bus.STATE_MON = 4'h0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (bus.START !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", bus.START); end
      n_cmp++; if (bus.POINTER !== 8'd0) begin n_fail++; $display("FAIL reset_pointer: got %0d want 0", bus.POINTER); end
      n_cmp++; if (bus.RUN !== 1'b0) begin n_fail++; $display("FAIL reset_run: got %b want 0", bus.RUN); end
      n_cmp++; if (bus.QUEUE_LEVEL !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", bus.QUEUE_LEVEL); end
      n_cmp++; if (bus.ERR !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", bus.ERR); end
   endtask

   task automatic test_start_gating();
      do_reset();
      bus.FIFO_USEDW = 12'd100;
      push(16'd200);
      n_cmp++; if (bus.QUEUE_LEVEL !== 4'd1) begin n_fail++; $display("FAIL gate_level: got %0d want 1", bus.QUEUE_LEVEL); end
      tick(); tick();
      n_cmp++; if (bus.START !== 1'b0 || bus.RUN !== 1'b0) begin n_fail++; $display("FAIL gate_low_fill: got start=%b run=%b want 0 0", bus.START, bus.RUN); end
      bus.FIFO_USEDW = 12'd184;
      tick();
      n_cmp++; if (bus.START !== 1'b1) begin n_fail++; $display("FAIL gate_start_pulse: got %b want 1", bus.START); end
      n_cmp++; if (bus.RUN !== 1'b1) begin n_fail++; $display("FAIL gate_run: got %b want 1", bus.RUN); end
      tick();
      n_cmp++; if (bus.START !== 1'b0) begin n_fail++; $display("FAIL gate_start_one_cycle: got %b want 0", bus.START); end
      tick();
      n_cmp++; if (bus.START !== 1'b0 || bus.RUN !== 1'b1) begin n_fail++; $display("FAIL gate_stay_running: got start=%b run=%b want 0 1", bus.START, bus.RUN); end
   endtask

   task automatic test_first_packets();
      do_reset();
      bus.FIFO_USEDW = 12'd184;
      push(16'd200);
      push(16'd300);
      tick();
      header();
      n_cmp++; if (bus.POINTER !== 8'd0) begin n_fail++; $display("FAIL first_hdr1: got %0d want 0", bus.POINTER); end
      take(183);
      header();
      n_cmp++; if (bus.POINTER !== 8'd17) begin n_fail++; $display("FAIL first_hdr2: got %0d want 17", bus.POINTER); end
      take(183);
      header();
      n_cmp++; if (bus.POINTER !== 8'd134) begin n_fail++; $display("FAIL first_hdr3: got %0d want 134", bus.POINTER); end
      n_cmp++; if (bus.QUEUE_LEVEL !== 4'd0) begin n_fail++; $display("FAIL first_level: got %0d want 0", bus.QUEUE_LEVEL); end
   endtask

   task automatic test_long_packet();
      do_reset();
      bus.FIFO_USEDW = 12'd184;
      push(16'd550);
      push(16'd100);
      tick();
      header();
      n_cmp++; if (bus.POINTER !== 8'd0) begin n_fail++; $display("FAIL long_hdr1: got %0d want 0", bus.POINTER); end
      take(183);
      header();
      n_cmp++; if (bus.POINTER !== 8'hFF) begin n_fail++; $display("FAIL long_hdr2: got %0d want 255", bus.POINTER); end
      take(184);
      header();
      n_cmp++; if (bus.POINTER !== 8'd183) begin n_fail++; $display("FAIL long_hdr3: got %0d want 183", bus.POINTER); end
      take(183);
      header();
      n_cmp++; if (bus.POINTER !== 8'd0) begin n_fail++; $display("FAIL long_hdr4: got %0d want 0", bus.POINTER); end
      n_cmp++; if (bus.QUEUE_LEVEL !== 4'd1) begin n_fail++; $display("FAIL long_level_before_pop: got %0d want 1", bus.QUEUE_LEVEL); end
      take(1);
      header();
      n_cmp++; if (bus.POINTER !== 8'd99) begin n_fail++; $display("FAIL long_hdr5: got %0d want 99", bus.POINTER); end
      n_cmp++; if (bus.ERR !== 2'b00) begin n_fail++; $display("FAIL long_err: got %b want 00", bus.ERR); end
   endtask

   task automatic test_overflow();
      do_reset();
      bus.FIFO_USEDW = 12'd0;
      for (int i = 0; i < 8; i++) push(16'(10 + i));
      n_cmp++; if (bus.QUEUE_LEVEL !== 4'd8 || bus.ERR !== 2'b00) begin n_fail++; $display("FAIL ovf_full_no_err: got level=%0d err=%b want 8 00", bus.QUEUE_LEVEL, bus.ERR); end
      push(16'd18);
      n_cmp++; if (bus.QUEUE_LEVEL !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", bus.QUEUE_LEVEL); end
      n_cmp++; if (bus.ERR !== 2'b01) begin n_fail++; $display("FAIL ovf_err: got %b want 01", bus.ERR); end
      bus.CLR_ERR = 1'b1; tick(); bus.CLR_ERR = 1'b0;
      n_cmp++; if (bus.ERR !== 2'b00) begin n_fail++; $display("FAIL ovf_clear: got %b want 00", bus.ERR); end
      push(16'd0);
      n_cmp++; if (bus.ERR !== 2'b01 || bus.QUEUE_LEVEL !== 4'd8) begin n_fail++; $display("FAIL zero_len: got err=%b level=%0d want 01 8", bus.ERR, bus.QUEUE_LEVEL); end
      bus.CLR_ERR = 1'b1; tick(); bus.CLR_ERR = 1'b0;
      // Push and pop together while full: both happen, no error.
      bus.LEN_IN = 16'd5; bus.LEN_WR = 1'b1; bus.BYTE_TAKEN = 1'b1;
      tick();
      bus.LEN_WR = 1'b0; bus.BYTE_TAKEN = 1'b0;
      n_cmp++; if (bus.QUEUE_LEVEL !== 4'd8 || bus.ERR !== 2'b00) begin n_fail++; $display("FAIL full_push_pop: got level=%0d err=%b want 8 00", bus.QUEUE_LEVEL, bus.ERR); end
      // First entry was 10, so 9 bytes of it remain after that pop.
      header();
      n_cmp++; if (bus.POINTER !== 8'd9) begin n_fail++; $display("FAIL full_pop_rem: got %0d want 9", bus.POINTER); end
      bus.CLR_ERR = 1'b1; bus.LEN_IN = 16'd0; bus.LEN_WR = 1'b1;
      tick();
      bus.CLR_ERR = 1'b0; bus.LEN_WR = 1'b0;
      n_cmp++; if (bus.ERR !== 2'b00) begin n_fail++; $display("FAIL clr_priority: got %b want 00", bus.ERR); end
   endtask

   task automatic test_underflow();
      do_reset();
      bus.FIFO_USEDW = 12'd0;
      push(16'd20);
      take(1);
      header();
      n_cmp++; if (bus.POINTER !== 8'd19) begin n_fail++; $display("FAIL unf_rem19: got %0d want 19", bus.POINTER); end
      take(19);
      n_cmp++; if (bus.ERR !== 2'b00) begin n_fail++; $display("FAIL unf_no_err_at_20: got %b want 00", bus.ERR); end
      take(1);
      n_cmp++; if (bus.ERR !== 2'b10) begin n_fail++; $display("FAIL unf_err: got %b want 10", bus.ERR); end
      header();
      n_cmp++; if (bus.POINTER !== 8'd0) begin n_fail++; $display("FAIL unf_rem_zero: got %0d want 0", bus.POINTER); end
      n_cmp++; if (bus.QUEUE_LEVEL !== 4'd0) begin n_fail++; $display("FAIL unf_level: got %0d want 0", bus.QUEUE_LEVEL); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      bus.FIFO_USEDW = 12'd200;
      push(16'd150); push(16'd50); push(16'd60); push(16'd70);
      tick();
      take(50);
      header();
      n_cmp++; if (bus.POINTER !== 8'd100 || bus.QUEUE_LEVEL !== 4'd3 || bus.RUN !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got ptr=%0d level=%0d run=%b want 100 3 1", bus.POINTER, bus.QUEUE_LEVEL, bus.RUN); end
      bus.LEN_IN = 16'd0; bus.LEN_WR = 1'b1;
      tick();
      bus.LEN_WR = 1'b0;
      do_reset();
      n_cmp++; if (bus.START !== 1'b0 || bus.POINTER !== 8'd0 || bus.RUN !== 1'b0) begin n_fail++; $display("FAIL mid_rst_outs: got start=%b ptr=%0d run=%b want 0 0 0", bus.START, bus.POINTER, bus.RUN); end
      n_cmp++; if (bus.QUEUE_LEVEL !== 4'd0 || bus.ERR !== 2'b00) begin n_fail++; $display("FAIL mid_rst_queue: got level=%0d err=%b want 0 00", bus.QUEUE_LEVEL, bus.ERR); end
      tick();
      n_cmp++; if (bus.START !== 1'b0) begin n_fail++; $display("FAIL mid_no_start_empty: got %b want 0", bus.START); end
      push(16'd188);
      n_cmp++; if (bus.START !== 1'b0) begin n_fail++; $display("FAIL mid_start_early: got %b want 0", bus.START); end
      tick();
      n_cmp++; if (bus.START !== 1'b1 || bus.RUN !== 1'b1) begin n_fail++; $display("FAIL mid_restart: got start=%b run=%b want 1 1", bus.START, bus.RUN); end
      header();
      n_cmp++; if (bus.POINTER !== 8'd0) begin n_fail++; $display("FAIL mid_first_ptr: got %0d want 0", bus.POINTER); end
      take(1);
      header();
      n_cmp++; if (bus.POINTER !== 8'hFF) begin n_fail++; $display("FAIL mid_long_ptr: got %0d want 255", bus.POINTER); end
   endtask

   initial begin
      bus.LEN_IN = 16'd0; bus.LEN_WR = 1'b0; bus.FIFO_USEDW = 12'd0;
      bus.BYTE_TAKEN = 1'b0; bus.STATE_MON = 4'h0; bus.CLR_ERR = 1'b0;
      test_reset();
      test_start_gating();
      test_first_packets();
      test_long_packet();
      test_overflow();
      test_underflow();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
